player_control_gen: RTL

Parametrised successor of the single-board player controller for the road-crossing game.
- Owns player grid position, N-lane AABB collision, lives, BCD level counter and car-speed output.
- Adds: reset, input synchronisers, hold-to-repeat movement, post-hit invulnerability window, explicit GAME_OVER state, per-lane enable mask.
- Sits between the switch inputs / car movers and the VGA renderer, seven-segment driver and LEDs.

---
 rtl/player_control_gen.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/player_control_gen.sv
// rtl/player_control_gen.sv - player position, lane collision, lives, BCD level and car speed for the road-crossing game
module player_control_gen #(
    parameter int H_DISPLAY    = 640,
    parameter int V_DISPLAY    = 480,
    parameter int STEP         = 32,
    parameter int PLAYER_W     = 32,
    parameter int PLAYER_H     = 32,
    parameter int CAR_W        = 64,
    parameter int CAR_H        = 32,
    parameter int N_LANES      = 8,
    parameter int LANE_Y0      = 64,
    parameter int MOVE_TICKS   = 2500000,
    parameter int LIVES        = 4,
    parameter int INVULN_TICKS = 25000000,
    parameter int SPEED_MAX    = 31
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   SW1,
    input  logic                   SW2,
    input  logic                   SW3,
    input  logic                   SW4,
    input  logic [10*N_LANES-1:0]  car_x,
    input  logic [N_LANES-1:0]     lane_en,
    output logic [9:0]             player_x,
    output logic [9:0]             player_y,
    output logic [LIVES-1:0]       lives,
    output logic [3:0]             level_tens,
    output logic [3:0]             level_units,
    output logic [4:0]             speed_car,
    output logic                   game_over,
    output logic                   hit_pulse,
    output logic                   level_pulse
);

    localparam int MW = $clog2(MOVE_TICKS + 1);
    localparam int IW = $clog2(INVULN_TICKS + 1);

    localparam logic [1:0] S_PLAY = 2'd0;
    localparam logic [1:0] S_HIT  = 2'd1;
    localparam logic [1:0] S_OVER = 2'd2;

    localparam logic [9:0]    START_X   = 10'(H_DISPLAY / 2);
    localparam logic [9:0]    START_Y   = 10'(V_DISPLAY - PLAYER_H);
    localparam logic [9:0]    MAX_X     = 10'(H_DISPLAY - PLAYER_W);
    localparam logic [9:0]    STEP_V    = 10'(STEP);
    localparam logic [10:0]   PW_W      = 11'(PLAYER_W);
    localparam logic [10:0]   PH_W      = 11'(PLAYER_H);
    localparam logic [10:0]   CW_W      = 11'(CAR_W);
    localparam logic [10:0]   CH_W      = 11'(CAR_H);
    localparam logic [MW-1:0] MOVE_LOAD = MW'(MOVE_TICKS);
    localparam logic [IW-1:0] INV_LOAD  = IW'(INVULN_TICKS);
    localparam logic [4:0]    SPEED_LIM = 5'(SPEED_MAX);

    logic [1:0]    state;
    logic [3:0]    sw_raw;
    logic [3:0]    sw_meta;
    logic [3:0]    sw_sync;
    logic [3:0]    sw_prev;
    logic [3:0]    sw_rise;
    logic          restart;
    logic          active;
    logic [MW-1:0] move_tmr;
    logic [MW-1:0] move_tmr_nxt;
    logic [IW-1:0] inv_tmr;
    logic          do_move;
    logic [9:0]    mv_x;
    logic [9:0]    mv_y;
    logic          overlap;
    logic          hit_q;
    logic [10:0]   px_w;
    logic [10:0]   py_w;
    logic [10:0]   lane_cx;
    logic [10:0]   lane_y;

    assign sw_raw    = {SW4, SW3, SW2, SW1};
    assign sw_rise   = sw_sync & ~sw_prev;
    assign restart   = &sw_sync;
    assign active    = (state != S_OVER);
    assign game_over = (state == S_OVER);
    assign px_w      = {1'b0, player_x};
    assign py_w      = {1'b0, player_y};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sw_meta <= 4'd0;
            sw_sync <= 4'd0;
            sw_prev <= 4'd0;
        end else begin
            sw_meta <= sw_raw;
            sw_sync <= sw_meta;
            sw_prev <= sw_sync;
        end
    end

    // A fresh press moves at once; a held switch repeats whenever the timer runs out.
    always_comb begin
        do_move      = 1'b0;
        move_tmr_nxt = move_tmr;
        if (!active) begin
            move_tmr_nxt = '0;
        end else if (|sw_rise) begin
            do_move      = 1'b1;
            move_tmr_nxt = MOVE_LOAD;
        end else if (|sw_sync) begin
            if (move_tmr <= MW'(1)) begin
                do_move      = 1'b1;
                move_tmr_nxt = MOVE_LOAD;
            end else begin
                move_tmr_nxt = move_tmr - MW'(1);
            end
        end else begin
            move_tmr_nxt = '0;
        end
    end

    always_comb begin
        mv_x = player_x;
        mv_y = player_y;
        if (sw_sync[0]) begin
            if (player_y != 10'd0) mv_y = player_y - STEP_V;
        end else if (sw_sync[1]) begin
            if (player_y < START_Y) mv_y = player_y + STEP_V;
        end else if (sw_sync[2]) begin
            if (player_x != 10'd0) mv_x = player_x - STEP_V;
        end else if (sw_sync[3]) begin
            if (player_x < MAX_X) mv_x = player_x + STEP_V;
        end
    end

    // Bounding-box tests are widened to 11 bits so edge sums near 1023 cannot wrap.
    always_comb begin
        overlap = 1'b0;
        lane_cx = 11'd0;
        lane_y  = 11'd0;
        for (int k = 0; k < N_LANES; k++) begin
            lane_cx = {1'b0, car_x[10*k +: 10]};
            lane_y  = 11'(LANE_Y0 + k * STEP);
            if (lane_en[k] &&
                (px_w + PW_W > lane_cx) && (px_w < lane_cx + CW_W) &&
                (py_w + PH_W > lane_y)  && (py_w < lane_y + CH_W))
                overlap = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= S_PLAY;
            player_x    <= START_X;
            player_y    <= START_Y;
            lives       <= '1;
            level_tens  <= 4'd0;
            level_units <= 4'd0;
            speed_car   <= 5'd0;
            move_tmr    <= '0;
            inv_tmr     <= '0;
            hit_q       <= 1'b0;
            hit_pulse   <= 1'b0;
            level_pulse <= 1'b0;
        end else begin
            hit_pulse   <= 1'b0;
            level_pulse <= 1'b0;
            if (restart) begin
                state       <= S_PLAY;
                player_x    <= START_X;
                player_y    <= START_Y;
                lives       <= '1;
                level_tens  <= 4'd0;
                level_units <= 4'd0;
                speed_car   <= 5'd0;
                move_tmr    <= '0;
                inv_tmr     <= '0;
                hit_q       <= 1'b0;
            end else begin
                hit_q    <= overlap;
                move_tmr <= move_tmr_nxt;
                if (state == S_PLAY && hit_q) begin
                    player_x  <= START_X;
                    player_y  <= START_Y;
                    lives     <= lives >> 1;
                    hit_pulse <= 1'b1;
                    if (lives == LIVES'(1)) begin
                        state <= S_OVER;
                    end else begin
                        state   <= S_HIT;
                        inv_tmr <= INV_LOAD;
                    end
                end else if (active) begin
                    if (state == S_HIT) begin
                        if (inv_tmr <= IW'(1)) begin
                            inv_tmr <= '0;
                            state   <= S_PLAY;
                        end else begin
                            inv_tmr <= inv_tmr - IW'(1);
                        end
                    end
                    // Reaching the top row takes precedence over any move this cycle.
                    if (player_y == 10'd0) begin
                        player_x    <= START_X;
                        player_y    <= START_Y;
                        level_pulse <= 1'b1;
                        if (level_units == 4'd9) begin
                            if (level_tens != 4'd9) begin
                                level_units <= 4'd0;
                                level_tens  <= level_tens + 4'd1;
                            end
                        end else begin
                            level_units <= level_units + 4'd1;
                        end
                        if (speed_car != SPEED_LIM) speed_car <= speed_car + 5'd1;
                    end else if (do_move) begin
                        player_x <= mv_x;
                        player_y <= mv_y;
                    end
                end
            end
        end
    end

endmodule
